// File: rtl/switch_mcu_alu_seq.sv
// switch_mcu_alu_seq: sequences one decoded instruction at a time onto one of
// eight ALU units. It broadcasts a cycle count, pulses done after the last
// execution cycle, and muxes the selected unit's register-file port requests
// through to a single register-file port.
//
// Handshake: an instruction transfers on a rising edge where in_dec_valid and
// out_dec_ready are both high. out_dec_ready is high only in IDLE. The decoder
// holds in_dec_valid and its payload stable until the transfer happens.
module switch_mcu_alu_seq (
    input  logic         in_clk,
    input  logic         in_rst,
    input  logic         in_dec_valid,
    output logic         out_dec_ready,
    input  logic [2:0]   in_dec_unit,
    input  logic [3:0]   in_dec_len,
    input  logic         in_flush,
    output logic [7:0]   out_unit_en,
    output logic [3:0]   out_cycle_cnt,
    output logic         out_done,
    input  logic [7:0]   in_unit_ren,
    input  logic [39:0]  in_unit_raddr,
    input  logic [7:0]   in_unit_wen,
    input  logic [39:0]  in_unit_waddr,
    input  logic [255:0] in_unit_wdata,
    output logic         out_rf_ren,
    output logic [4:0]   out_rf_raddr,
    output logic         out_rf_wen,
    output logic [4:0]   out_rf_waddr,
    output logic [31:0]  out_rf_wdata,
    output logic         out_port_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t     state;
    logic [2:0] unit_q;
    logic [3:0] len_q;
    logic       accept;
    logic [7:0] sel_mask;
    logic [7:0] req_any;
    logic       port_err_next;

    assign out_dec_ready = (state == IDLE);
    assign accept        = in_dec_valid && out_dec_ready;
    assign sel_mask      = 8'b1 << unit_q;
    assign req_any       = in_unit_ren | in_unit_wen;

    // In IDLE no unit owns the port, so any request is a violation.
    // Otherwise only the selected unit may request.
    assign port_err_next = (state == IDLE) ? (|req_any) : (|(req_any & ~sel_mask));

    // Port mux: forward only the selected unit's fields. DRAIN keeps the mux
    // open so a write issued on the last execution cycle still lands.
    always_comb begin
        out_rf_ren   = 1'b0;
        out_rf_raddr = 5'd0;
        out_rf_wen   = 1'b0;
        out_rf_waddr = 5'd0;
        out_rf_wdata = 32'd0;
        if (state != IDLE) begin
            for (int k = 0; k < 8; k++) begin
                if (unit_q == 3'(k)) begin
                    out_rf_ren   = in_unit_ren[k];
                    out_rf_raddr = in_unit_raddr[5*k +: 5];
                    out_rf_wen   = in_unit_wen[k];
                    out_rf_waddr = in_unit_waddr[5*k +: 5];
                    out_rf_wdata = in_unit_wdata[32*k +: 32];
                end
            end
        end
    end

    // Sequencer FSM with registered enable, count, done and error outputs.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state         <= IDLE;
            unit_q        <= 3'd0;
            len_q         <= 4'd0;
            out_unit_en   <= 8'd0;
            out_cycle_cnt <= 4'd0;
            out_done      <= 1'b0;
            out_port_err  <= 1'b0;
        end else begin
            out_port_err <= port_err_next;
            case (state)
                IDLE: begin
                    out_done <= 1'b0;
                    // Flush is meaningless here; an accept proceeds regardless.
                    if (accept) begin
                        unit_q        <= in_dec_unit;
                        // Lengths below 4 are clamped to the minimum of 4 cycles.
                        len_q         <= (in_dec_len < 4'd4) ? 4'd4 : in_dec_len;
                        out_unit_en   <= 8'b1 << in_dec_unit;
                        out_cycle_cnt <= 4'd1;
                        state         <= EXEC;
                    end
                end
                EXEC: begin
                    if (in_flush) begin
                        // Flush wins over completion: no done pulse.
                        state         <= IDLE;
                        out_unit_en   <= 8'd0;
                        out_cycle_cnt <= 4'd0;
                        out_done      <= 1'b0;
                    end else if (out_cycle_cnt == len_q) begin
                        state         <= DRAIN;
                        out_unit_en   <= 8'd0;
                        out_cycle_cnt <= 4'd0;
                        out_done      <= 1'b1;
                    end else begin
                        // Stops at len_q (at most 15), so it never wraps.
                        out_cycle_cnt <= out_cycle_cnt + 4'd1;
                    end
                end
                DRAIN: begin
                    state         <= IDLE;
                    out_unit_en   <= 8'd0;
                    out_cycle_cnt <= 4'd0;
                    out_done      <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    out_unit_en   <= 8'd0;
                    out_cycle_cnt <= 4'd0;
                    out_done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_mcu_alu_seq.sv
// Testbench for switch_mcu_alu_seq: table of instruction runs plus directed
// sequences for port muxing, port errors, flush, back-to-back and reset.
module tb_switch_mcu_alu_seq;

    logic         clk;
    logic         rst;
    logic         dec_valid;
    logic         dec_ready;
    logic [2:0]   dec_unit;
    logic [3:0]   dec_len;
    logic         flush;
    logic [7:0]   unit_en;
    logic [3:0]   cycle_cnt;
    logic         done;
    logic [7:0]   unit_ren;
    logic [39:0]  unit_raddr;
    logic [7:0]   unit_wen;
    logic [39:0]  unit_waddr;
    logic [255:0] unit_wdata;
    logic         rf_ren;
    logic [4:0]   rf_raddr;
    logic         rf_wen;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata;
    logic         port_err;

    int n_checks;
    int n_errors;

    switch_mcu_alu_seq dut (
        .in_clk        (clk),
        .in_rst        (rst),
        .in_dec_valid  (dec_valid),
        .out_dec_ready (dec_ready),
        .in_dec_unit   (dec_unit),
        .in_dec_len    (dec_len),
        .in_flush      (flush),
        .out_unit_en   (unit_en),
        .out_cycle_cnt (cycle_cnt),
        .out_done      (done),
        .in_unit_ren   (unit_ren),
        .in_unit_raddr (unit_raddr),
        .in_unit_wen   (unit_wen),
        .in_unit_waddr (unit_waddr),
        .in_unit_wdata (unit_wdata),
        .out_rf_ren    (rf_ren),
        .out_rf_raddr  (rf_raddr),
        .out_rf_wen    (rf_wen),
        .out_rf_waddr  (rf_waddr),
        .out_rf_wdata  (rf_wdata),
        .out_port_err  (port_err)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0] unit;
        logic [3:0] len;
        logic [7:0] exp_en;
        logic [3:0] exp_last;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ports();
        unit_ren   = '0;
        unit_raddr = '0;
        unit_wen   = '0;
        unit_waddr = '0;
        unit_wdata = '0;
    endtask

    task automatic accept(input logic [2:0] u, input logic [3:0] l);
        chk("ready_before_accept", {31'd0, dec_ready}, 32'd1);
        dec_valid = 1'b1;
        dec_unit  = u;
        dec_len   = l;
        tick();
        dec_valid = 1'b0;
    endtask

    // Full instruction run from IDLE back to IDLE, checking every cycle.
    task automatic run_instr(input logic [2:0] u, input logic [3:0] l,
                             input logic [7:0] exp_en, input logic [3:0] exp_last);
        accept(u, l);
        for (int c = 1; c <= int'(exp_last); c++) begin
            chk("run_cnt", {28'd0, cycle_cnt}, 32'(c));
            chk("run_en", {24'd0, unit_en}, {24'd0, exp_en});
            chk("run_done_low", {31'd0, done}, 32'd0);
            chk("run_ready_low", {31'd0, dec_ready}, 32'd0);
            tick();
        end
        chk("drain_done", {31'd0, done}, 32'd1);
        chk("drain_en", {24'd0, unit_en}, 32'd0);
        chk("drain_cnt", {28'd0, cycle_cnt}, 32'd0);
        tick();
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_ready", {31'd0, dec_ready}, 32'd1);
    endtask

    initial begin
        int  gap;
        bit  seen;
        logic [3:0] max_cnt;

        n_checks = 0;
        n_errors = 0;

        vecs[0] = '{unit: 3'd3, len: 4'd4,  exp_en: 8'h08, exp_last: 4'd4};
        vecs[1] = '{unit: 3'd0, len: 4'd0,  exp_en: 8'h01, exp_last: 4'd4};
        vecs[2] = '{unit: 3'd1, len: 4'd2,  exp_en: 8'h02, exp_last: 4'd4};
        vecs[3] = '{unit: 3'd7, len: 4'd15, exp_en: 8'h80, exp_last: 4'd15};
        vecs[4] = '{unit: 3'd5, len: 4'd9,  exp_en: 8'h20, exp_last: 4'd9};
        vecs[5] = '{unit: 3'd6, len: 4'd3,  exp_en: 8'h40, exp_last: 4'd4};
        vecs[6] = '{unit: 3'd2, len: 4'd5,  exp_en: 8'h04, exp_last: 4'd5};

        // Reset
        rst       = 1'b1;
        dec_valid = 1'b0;
        dec_unit  = 3'd0;
        dec_len   = 4'd0;
        flush     = 1'b0;
        clear_ports();
        #3;
        chk("rst_en", {24'd0, unit_en}, 32'd0);
        chk("rst_cnt", {28'd0, cycle_cnt}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, port_err}, 32'd0);
        chk("rst_rf_wen", {31'd0, rf_wen}, 32'd0);
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", {31'd0, dec_ready}, 32'd1);

        // Table of instruction runs
        for (int i = 0; i < 7; i++) begin
            run_instr(vecs[i].unit, vecs[i].len, vecs[i].exp_en, vecs[i].exp_last);
        end

        // Write from unit 3 on the DRAIN cycle reaches the register file
        accept(3'd3, 4'd4);
        tick(); tick(); tick();
        chk("wr_cnt4", {28'd0, cycle_cnt}, 32'd4);
        unit_wen[3]          = 1'b1;
        unit_waddr[19:15]    = 5'd7;
        unit_wdata[127:96]   = 32'h10;
        unit_wdata[31:0]     = 32'hdead;
        tick();
        chk("wr_drain_done", {31'd0, done}, 32'd1);
        chk("wr_rf_wen", {31'd0, rf_wen}, 32'd1);
        chk("wr_rf_waddr", {27'd0, rf_waddr}, 32'd7);
        chk("wr_rf_wdata", rf_wdata, 32'h10);
        tick();
        chk("wr_no_err_in_drain", {31'd0, port_err}, 32'd0);
        chk("wr_idle_gated", {31'd0, rf_wen}, 32'd0);
        chk("wr_idle_wdata_gated", rf_wdata, 32'd0);
        tick();
        chk("wr_idle_err", {31'd0, port_err}, 32'd1);
        clear_ports();
        tick();
        chk("wr_idle_err_clear", {31'd0, port_err}, 32'd0);

        // Back-to-back len=15 with valid held; changed payload ignored in EXEC
        dec_valid = 1'b1;
        dec_unit  = 3'd7;
        dec_len   = 4'd15;
        tick();
        chk("b2b_first_cnt", {28'd0, cycle_cnt}, 32'd1);
        dec_unit = 3'd2;
        gap = 0;
        seen = 1'b0;
        max_cnt = 4'd0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            tick();
            if (i == 1) chk("b2b_held_valid_ignored", {24'd0, unit_en}, 32'h80);
            if (cycle_cnt > max_cnt) max_cnt = cycle_cnt;
            if (cycle_cnt == 4'd1 && unit_en == 8'h04) begin
                gap  = i;
                seen = 1'b1;
            end
        end
        chk("b2b_gap", 32'(gap), 32'd17);
        chk("b2b_max_cnt", {28'd0, max_cnt}, 32'd15);
        dec_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("b2b_flush_idle", {31'd0, dec_ready}, 32'd1);

        // Flush at cnt=2
        accept(3'd1, 4'd6);
        tick();
        chk("fl_cnt2", {28'd0, cycle_cnt}, 32'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_en", {24'd0, unit_en}, 32'd0);
        chk("fl_cnt", {28'd0, cycle_cnt}, 32'd0);
        chk("fl_done", {31'd0, done}, 32'd0);
        chk("fl_ready", {31'd0, dec_ready}, 32'd1);
        tick();
        chk("fl_no_late_done", {31'd0, done}, 32'd0);

        // Flush coinciding with the last cycle suppresses done
        accept(3'd0, 4'd4);
        tick(); tick(); tick();
        chk("fl_last_cnt4", {28'd0, cycle_cnt}, 32'd4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_last_done", {31'd0, done}, 32'd0);
        chk("fl_last_ready", {31'd0, dec_ready}, 32'd1);

        // Flush in IDLE ignored; accept in same cycle proceeds
        flush     = 1'b1;
        dec_valid = 1'b1;
        dec_unit  = 3'd6;
        dec_len   = 4'd7;
        tick();
        flush     = 1'b0;
        dec_valid = 1'b0;
        chk("fl_idle_accept_cnt", {28'd0, cycle_cnt}, 32'd1);
        chk("fl_idle_accept_en", {24'd0, unit_en}, 32'h40);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // Port errors: unit 5 requests while unit 2 is selected
        accept(3'd2, 4'd8);
        unit_ren[5]         = 1'b1;
        unit_raddr[29:25]   = 5'h1a;
        #1;
        chk("pe_rf_ren_blocked", {31'd0, rf_ren}, 32'd0);
        chk("pe_rf_raddr_blocked", {27'd0, rf_raddr}, 32'd0);
        tick();
        chk("pe_err_set", {31'd0, port_err}, 32'd1);
        unit_ren            = 8'h04;
        unit_raddr[14:10]   = 5'h05;
        #1;
        chk("pe_rf_ren_sel", {31'd0, rf_ren}, 32'd1);
        chk("pe_rf_raddr_sel", {27'd0, rf_raddr}, 32'h05);
        tick();
        chk("pe_err_clear", {31'd0, port_err}, 32'd0);
        unit_wen[6] = 1'b1;
        tick();
        chk("pe_wen_other", {31'd0, port_err}, 32'd1);
        chk("pe_rf_wen_blocked", {31'd0, rf_wen}, 32'd0);
        clear_ports();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        unit_ren[0] = 1'b1;
        #1;
        chk("pe_idle_rf_ren", {31'd0, rf_ren}, 32'd0);
        tick();
        chk("pe_idle_err", {31'd0, port_err}, 32'd1);
        clear_ports();
        tick();
        chk("pe_idle_err_clear", {31'd0, port_err}, 32'd0);

        // Asynchronous reset mid-EXEC at cnt=3
        accept(3'd4, 4'd10);
        tick(); tick();
        chk("ar_cnt3", {28'd0, cycle_cnt}, 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_en", {24'd0, unit_en}, 32'd0);
        chk("ar_cnt", {28'd0, cycle_cnt}, 32'd0);
        chk("ar_done", {31'd0, done}, 32'd0);
        chk("ar_err", {31'd0, port_err}, 32'd0);
        tick();
        chk("ar_hold_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ar_ready", {31'd0, dec_ready}, 32'd1);
        tick();
        chk("ar_no_done", {31'd0, done}, 32'd0);
        run_instr(3'd4, 4'd10, 8'h10, 4'd10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
